// File: rtl/snek_game_ctrl.sv
// snek game sequencer: splash/play/dead/restart FSM, frame tick with speed ramp,
// direction latch and eat/food pulses. Optional pause input under SNEK_PAUSE_EN.
module snek_game_ctrl #(
  parameter int MS_CYCLES   = 12500,
  parameter int SPLASH_MS   = 10000,
  parameter int BASE_PERIOD = 3125000,
  parameter int STEP_PERIOD = 200000,
  parameter int MIN_PERIOD  = 625000,
  parameter int DEAD_FRAMES = 8,
  parameter int GRID_V      = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] buttons,
  input  logic [5:0] head_h,
  input  logic [5:0] head_v,
  input  logic [4:0] food_h,
  input  logic [4:0] food_v,
  input  logic [7:0] snek_len,
  input  logic       dead,
`ifdef SNEK_PAUSE_EN
  input  logic       pause_btn,
`endif
  output logic       frame_tick,
  output logic [2:0] dir,
  output logic       grow_flag,
  output logic       new_food_flag,
  output logic       game_rst,
  output logic       run,
  output logic [1:0] state
);

  localparam logic [1:0] S_SPLASH  = 2'd0;
  localparam logic [1:0] S_PLAY    = 2'd1;
  localparam logic [1:0] S_DEAD    = 2'd2;
  localparam logic [1:0] S_RESTART = 2'd3;

  logic [31:0]        ms_pre, ms_cnt, frame_ctr, period, dead_cnt;
  logic [2:0]         pending, pend_nxt;
  logic               eat_lock, on_food, eat, paused;
  logic signed [31:0] p_raw;
  logic [31:0]        p_next;

  // Signed math so long snakes clamp to the floor instead of wrapping.
  always_comb begin
    p_raw  = BASE_PERIOD - STEP_PERIOD * $signed({24'd0, snek_len});
    p_next = (p_raw < MIN_PERIOD) ? 32'(MIN_PERIOD) : $unsigned(p_raw);
  end

  // Highest-priority pressed button that is not a reversal of the committed direction.
  always_comb begin
    pend_nxt = pending;
    if      (buttons[1] && dir != 3'd1) pend_nxt = 3'd0;
    else if (buttons[0] && dir != 3'd0) pend_nxt = 3'd1;
    else if (buttons[2] && dir != 3'd3) pend_nxt = 3'd2;
    else if (buttons[3] && dir != 3'd2) pend_nxt = 3'd3;
  end

  assign on_food       = (head_h == {1'b0, food_h}) && (head_v == {1'b0, food_v});
  assign frame_tick    = (state == S_PLAY) && !paused && (frame_ctr == period - 32'd1);
  assign eat           = (state == S_PLAY) && !paused && on_food && !eat_lock && !dead;
  assign grow_flag     = eat;
  assign new_food_flag = eat || ((state != S_SPLASH) && ({27'd0, food_v} >= 32'(GRID_V)));
  assign game_rst      = (state == S_RESTART);
  assign run           = (state == S_PLAY) || (state == S_DEAD);

`ifdef SNEK_PAUSE_EN
  logic pause_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pause_q <= 1'b0;
      paused  <= 1'b0;
    end else begin
      pause_q <= pause_btn;
      if (state != S_PLAY || dead)     paused <= 1'b0;
      else if (pause_btn && !pause_q)  paused <= !paused;
    end
  end
`else
  assign paused = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_SPLASH;
      dir       <= 3'd0;
      pending   <= 3'd0;
      ms_pre    <= 32'd0;
      ms_cnt    <= 32'd0;
      frame_ctr <= 32'd0;
      period    <= 32'd0;
      dead_cnt  <= 32'd0;
      eat_lock  <= 1'b0;
    end else begin
      pending <= pend_nxt;
      if (frame_tick) dir <= pending;
      // Lock re-arms only on a tick where the head has moved off the food.
      if (eat)                          eat_lock <= 1'b1;
      else if (frame_tick && !on_food)  eat_lock <= 1'b0;

      case (state)
        S_SPLASH: begin
          if (ms_pre == 32'(MS_CYCLES - 1)) begin
            ms_pre <= 32'd0;
            if (ms_cnt == 32'(SPLASH_MS - 1)) begin
              ms_cnt <= 32'd0;
              state  <= S_RESTART;
            end else begin
              ms_cnt <= ms_cnt + 32'd1;
            end
          end else begin
            ms_pre <= ms_pre + 32'd1;
          end
        end
        S_RESTART: begin
          state     <= S_PLAY;
          dir       <= 3'd0;
          pending   <= 3'd0;
          frame_ctr <= 32'd0;
          period    <= p_next;
          eat_lock  <= 1'b0;
        end
        S_PLAY: begin
          if (dead) begin
            state     <= S_DEAD;
            frame_ctr <= 32'd0;
            dead_cnt  <= 32'd0;
          end else if (!paused) begin
            if (frame_ctr == period - 32'd1) begin
              frame_ctr <= 32'd0;
              period    <= p_next;
            end else begin
              frame_ctr <= frame_ctr + 32'd1;
            end
          end
        end
        S_DEAD: begin
          if (frame_ctr == 32'(BASE_PERIOD - 1)) begin
            frame_ctr <= 32'd0;
            if (dead_cnt == 32'(DEAD_FRAMES - 1)) begin
              dead_cnt <= 32'd0;
              state    <= S_RESTART;
            end else begin
              dead_cnt <= dead_cnt + 32'd1;
            end
          end else begin
            frame_ctr <= frame_ctr + 32'd1;
          end
        end
        default: state <= S_SPLASH;
      endcase
    end
  end

endmodule

// File: tb/tb_snek_game_ctrl.sv
// Self-checking bench for snek_game_ctrl with scaled-down timing parameters.
module tb_snek_game_ctrl;
  localparam int BASE = 20, STEP = 4, MINP = 8, DFR = 2;

  logic       clk = 1'b0, rst = 1'b1;
  logic [3:0] buttons = 4'd0;
  logic [5:0] head_h = 6'd9, head_v = 6'd9;
  logic [4:0] food_h = 5'd10, food_v = 5'd10;
  logic [7:0] snek_len = 8'd0;
  logic       dead = 1'b0;
`ifdef SNEK_PAUSE_EN
  logic       pause_btn = 1'b0;
`endif
  logic       frame_tick, grow_flag, new_food_flag, game_rst, run;
  logic [2:0] dir;
  logic [1:0] state;

  int n_chk = 0, n_pass = 0;

  snek_game_ctrl #(
    .MS_CYCLES(4), .SPLASH_MS(3), .BASE_PERIOD(BASE), .STEP_PERIOD(STEP),
    .MIN_PERIOD(MINP), .DEAD_FRAMES(DFR), .GRID_V(24)
  ) dut (
    .clk(clk), .rst(rst), .buttons(buttons), .head_h(head_h), .head_v(head_v),
    .food_h(food_h), .food_v(food_v), .snek_len(snek_len), .dead(dead),
`ifdef SNEK_PAUSE_EN
    .pause_btn(pause_btn),
`endif
    .frame_tick(frame_tick), .dir(dir), .grow_flag(grow_flag),
    .new_food_flag(new_food_flag), .game_rst(game_rst), .run(run), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic int exp_period(input int len);
    int p;
    p = BASE - STEP * len;
    return (p < MINP) ? MINP : p;
  endfunction

  // Priority left, right, up, down; a press reversing the committed direction is skipped.
  function automatic logic [2:0] model_turn(input logic [3:0] b, input logic [2:0] d,
                                            input logic [2:0] p);
    int btn_for_code [4];
    btn_for_code = '{1, 0, 2, 3};
    for (int c = 0; c < 4; c++)
      if (b[btn_for_code[c]] && c != (int'(d) ^ 1)) return 3'(c);
    return p;
  endfunction

  task automatic restart_game();
    int cnt;
    rst = 1'b1; buttons = 4'd0; dead = 1'b0;
    repeat (2) step();
    rst = 1'b0; cnt = 0;
    while (game_rst !== 1'b1 && cnt < 200) begin step(); cnt++; end
    n_chk++;
    if (game_rst !== 1'b1) $display("FAIL restart_timeout game_rst=%b after %0d cycles, required 1", game_rst, cnt);
    else n_pass++;
    step();
  endtask

  task automatic test_reset();
    int cnt, ticks;
    rst = 1'b1;
    repeat (2) step();
    n_chk++; if (state !== 2'd0) $display("FAIL rst_state got %0d want 0", state); else n_pass++;
    n_chk++; if (run !== 1'b0) $display("FAIL rst_run got %b want 0", run); else n_pass++;
    n_chk++; if (dir !== 3'd0) $display("FAIL rst_dir got %0d want 0", dir); else n_pass++;
    n_chk++; if ({frame_tick, grow_flag, new_food_flag, game_rst} !== 4'b0)
      $display("FAIL rst_pulses got %b want 0000", {frame_tick, grow_flag, new_food_flag, game_rst});
    else n_pass++;
    rst = 1'b0; cnt = 0; ticks = 0;
    while (state === 2'd0 && cnt < 100) begin
      if (frame_tick) ticks++;
      step(); cnt++;
    end
    n_chk++; if (cnt !== 12) $display("FAIL splash_len got %0d want 12", cnt); else n_pass++;
    n_chk++; if (ticks !== 0) $display("FAIL splash_ticks got %0d want 0", ticks); else n_pass++;
    n_chk++; if (state !== 2'd3 || game_rst !== 1'b1)
      $display("FAIL restart_cycle state=%0d game_rst=%b want 3/1", state, game_rst);
    else n_pass++;
    cnt = 0;
    step(); cnt++;
    n_chk++; if (state !== 2'd1 || run !== 1'b1 || game_rst !== 1'b0)
      $display("FAIL play_entry state=%0d run=%b game_rst=%b want 1/1/0", state, run, game_rst);
    else n_pass++;
    while (frame_tick !== 1'b1 && cnt < 200) begin step(); cnt++; end
    n_chk++; if (cnt !== exp_period(0)) $display("FAIL first_tick got %0d want %0d", cnt, exp_period(0)); else n_pass++;
  endtask

  task automatic test_period();
    int lens [8];
    int cnt;
    lens = '{0, 1, 3, 10, 0, 0, 0, 0};
    for (int i = 4; i < 8; i++) lens[i] = $urandom_range(0, 255);
    restart_game();
    for (int i = 0; i < 8; i++) begin
      snek_len = 8'(lens[i]);
      cnt = 0;
      while (frame_tick !== 1'b1 && cnt < 300) begin step(); cnt++; end
      step(); cnt = 1;
      while (frame_tick !== 1'b1 && cnt < 300) begin step(); cnt++; end
      n_chk++;
      if (cnt !== exp_period(lens[i]))
        $display("FAIL tick_spacing len=%0d got %0d want %0d", lens[i], cnt, exp_period(lens[i]));
      else n_pass++;
    end
    snek_len = 8'd0;
  endtask

  task automatic test_dir();
    logic [2:0] m_dir, m_pend, nxt;
    logic [3:0] b;
    logic       exp_tick;
    int         phase;
    restart_game();
    m_dir = 3'd0; m_pend = 3'd0; phase = 0;
    for (int cyc = 0; cyc < 240; cyc++) begin
      if (cyc < 60) b = (cyc == 5) ? 4'b0001 : (cyc == 25) ? 4'b0100 : (cyc == 45) ? 4'b1000 : 4'b0000;
      else b = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      buttons = b; #1;
      exp_tick = (phase == exp_period(0) - 1);
      n_chk++; if (frame_tick !== exp_tick) $display("FAIL dir_tick cyc=%0d got %b want %b", cyc, frame_tick, exp_tick); else n_pass++;
      n_chk++; if (dir !== m_dir) $display("FAIL dir_value cyc=%0d got %0d want %0d", cyc, dir, m_dir); else n_pass++;
      if (cyc == 59) begin
        n_chk++; if (dir !== 3'd2) $display("FAIL dir_up_kept got %0d want 2", dir); else n_pass++;
      end
      nxt = model_turn(b, m_dir, m_pend);
      if (exp_tick) m_dir = m_pend;
      m_pend = nxt;
      phase = exp_tick ? 0 : phase + 1;
      step();
    end
    buttons = 4'd0;
  endtask

  task automatic test_eat();
    logic on, armed, exp_grow, exp_tick;
    int   phase, pulses;
    restart_game();
    food_h = 5'd5; food_v = 5'd7;
    armed = 1'b1; phase = 0; pulses = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      on = (cyc >= 3 && cyc < 63) || (cyc >= 85 && cyc < 90);
      if (on) begin head_h = 6'd5; head_v = 6'd7; end
      else if (cyc >= 65 && cyc < 76) begin head_h = 6'd37; head_v = 6'd7; end
      else begin head_h = 6'd9; head_v = 6'd9; end
      #1;
      exp_tick = (phase == exp_period(0) - 1);
      exp_grow = on && armed;
      n_chk++; if (grow_flag !== exp_grow) $display("FAIL eat_grow cyc=%0d got %b want %b", cyc, grow_flag, exp_grow); else n_pass++;
      n_chk++; if (new_food_flag !== exp_grow) $display("FAIL eat_newfood cyc=%0d got %b want %b", cyc, new_food_flag, exp_grow); else n_pass++;
      if (grow_flag) pulses++;
      if (exp_grow) armed = 1'b0;
      else if (exp_tick && !on) armed = 1'b1;
      phase = exp_tick ? 0 : phase + 1;
      step();
    end
    n_chk++; if (pulses !== 2) $display("FAIL eat_pulse_count got %0d want 2", pulses); else n_pass++;
    head_h = 6'd9; head_v = 6'd9;
  endtask

  task automatic test_invalid_food();
    int  cnt;
    logic bad;
    head_h = 6'd40; head_v = 6'd40;
    rst = 1'b1; food_v = 5'd25;
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if (new_food_flag !== 1'b0) $display("FAIL splash_newfood got %b want 0", new_food_flag); else n_pass++;
      step();
    end
    cnt = 0;
    while (game_rst !== 1'b1 && cnt < 200) begin step(); cnt++; end
    n_chk++; if (new_food_flag !== 1'b1) $display("FAIL restart_newfood got %b want 1", new_food_flag); else n_pass++;
    step();
    for (int i = 0; i < 16; i++) begin
      bad = (i < 8) || ($urandom_range(0, 1) == 1);
      food_v = bad ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
      #1;
      n_chk++; if (new_food_flag !== bad) $display("FAIL invalid_food v=%0d got %b want %b", food_v, new_food_flag, bad); else n_pass++;
      step();
    end
    food_v = 5'd3; #1;
    n_chk++; if (new_food_flag !== 1'b0) $display("FAIL valid_food_quiet got %b want 0", new_food_flag); else n_pass++;
    food_h = 5'd10; food_v = 5'd10; head_h = 6'd9; head_v = 6'd9;
  endtask

  task automatic test_dead();
    int cnt, bad_tick, bad_run;
    restart_game();
    food_h = 5'd5; food_v = 5'd7;
    for (int cyc = 0; cyc < 22; cyc++) begin
      buttons = (cyc == 3) ? 4'b0100 : 4'b0000;
      step();
    end
    head_h = 6'd5; head_v = 6'd7; dead = 1'b1; #1;
    n_chk++; if (grow_flag !== 1'b0) $display("FAIL dead_eat_grow got %b want 0", grow_flag); else n_pass++;
    n_chk++; if (new_food_flag !== 1'b0) $display("FAIL dead_eat_newfood got %b want 0", new_food_flag); else n_pass++;
    n_chk++; if (dir !== 3'd2) $display("FAIL dead_pre_dir got %0d want 2", dir); else n_pass++;
    step();
    dead = 1'b0; head_h = 6'd9; head_v = 6'd9;
    cnt = 0; bad_tick = 0; bad_run = 0;
    while (state === 2'd2 && cnt < 200) begin
      if (frame_tick) bad_tick++;
      if (run !== 1'b1) bad_run++;
      buttons = 4'($urandom_range(0, 15));
      step(); cnt++;
    end
    buttons = 4'd0;
    n_chk++; if (cnt !== BASE * DFR) $display("FAIL dead_len got %0d want %0d", cnt, BASE * DFR); else n_pass++;
    n_chk++; if (bad_tick !== 0) $display("FAIL dead_ticks got %0d want 0", bad_tick); else n_pass++;
    n_chk++; if (bad_run !== 0) $display("FAIL dead_run_low got %0d want 0", bad_run); else n_pass++;
    n_chk++; if (state !== 2'd3 || game_rst !== 1'b1)
      $display("FAIL dead_restart state=%0d game_rst=%b want 3/1", state, game_rst);
    else n_pass++;
    step();
    n_chk++; if (state !== 2'd1 || dir !== 3'd0)
      $display("FAIL post_dead state=%0d dir=%0d want 1/0", state, dir);
    else n_pass++;
    repeat (exp_period(0)) step();
    n_chk++; if (dir !== 3'd0) $display("FAIL pending_cleared dir=%0d want 0", dir); else n_pass++;
    food_h = 5'd10; food_v = 5'd10;
  endtask

  task automatic test_midrst();
    restart_game();
    buttons = 4'b0100;
    repeat (25) step();
    buttons = 4'd0; rst = 1'b1;
    step();
    n_chk++; if (state !== 2'd0 || game_rst !== 1'b0 || run !== 1'b0 || dir !== 3'd0)
      $display("FAIL midrst state=%0d game_rst=%b run=%b dir=%0d want 0/0/0/0", state, game_rst, run, dir);
    else n_pass++;
    rst = 1'b0;
  endtask

`ifdef SNEK_PAUSE_EN
  task automatic test_pause();
    logic m_paused, prev_btn, on, armed, exp_tick, exp_grow, was_paused;
    int   phase, first_tick;
    restart_game();
    food_h = 5'd5; food_v = 5'd7;
    m_paused = 1'b0; prev_btn = 1'b0; armed = 1'b1; phase = 0; first_tick = -1;
    for (int cyc = 0; cyc < 160; cyc++) begin
      pause_btn = (cyc >= 5 && cyc < 8) || (cyc >= 110 && cyc < 113);
      on = (cyc >= 50 && cyc < 116);
      head_h = on ? 6'd5 : 6'd9; head_v = on ? 6'd7 : 6'd9;
      #1;
      exp_tick = !m_paused && (phase == exp_period(0) - 1);
      exp_grow = !m_paused && on && armed;
      n_chk++; if (state !== 2'd1) $display("FAIL pause_state cyc=%0d got %0d want 1", cyc, state); else n_pass++;
      n_chk++; if (frame_tick !== exp_tick) $display("FAIL pause_tick cyc=%0d got %b want %b", cyc, frame_tick, exp_tick); else n_pass++;
      n_chk++; if (grow_flag !== exp_grow) $display("FAIL pause_grow cyc=%0d got %b want %b", cyc, grow_flag, exp_grow); else n_pass++;
      if (frame_tick && cyc > 8 && first_tick < 0) first_tick = cyc;
      was_paused = m_paused;
      if (pause_btn && !prev_btn) m_paused = !m_paused;
      prev_btn = pause_btn;
      if (exp_grow) armed = 1'b0;
      else if (exp_tick && !on) armed = 1'b1;
      if (!was_paused) phase = exp_tick ? 0 : phase + 1;
      step();
    end
    n_chk++; if (first_tick !== 124) $display("FAIL resume_tick got %0d want 124", first_tick); else n_pass++;
    pause_btn = 1'b0; head_h = 6'd9; head_v = 6'd9; food_h = 5'd10; food_v = 5'd10;
  endtask
`endif

  initial begin
    test_reset();
    test_period();
    test_dir();
    test_eat();
    test_invalid_food();
    test_dead();
    test_midrst();
`ifdef SNEK_PAUSE_EN
    test_pause();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
